bmu_iter_unit: RTL



---
 rtl/bmu_iter_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bmu_iter_unit.sv
// bmu_iter_unit: chunked multi-cycle CLZ/CTZ/CPOP/BEXT/BDEP engine with valid/ready and flush.
// BDEP (op 4) is built only when BMU_BDEP_EN is defined; otherwise op 4 completes as illegal.
module bmu_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            ready,
  output logic            busy,
  output logic            valid_out,
  output logic [XLEN-1:0] result_ff,
  output logic            error
);
  localparam int K  = XLEN / CHUNK;
  localparam int CW = $clog2(K + 1);
  localparam int PW = $clog2(XLEN + 1);
  localparam logic [2:0] OP_CLZ  = 3'd0;
  localparam logic [2:0] OP_CTZ  = 3'd1;
  localparam logic [2:0] OP_CPOP = 3'd2;
  localparam logic [2:0] OP_BEXT = 3'd3;
  localparam logic [2:0] OP_BDEP = 3'd4;

  if (XLEN % CHUNK != 0) begin : g_bad_params
    $error("bmu_iter_unit: XLEN must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            found_q, found_d, err_q, err_d;
  logic            legal;
  logic [CW-1:0]   cidx;
  int              base;
  logic [CHUNK-1:0] ca, cb;
  logic [XLEN-1:0] acc_v;
  logic [PW-1:0]   ptr_v;
  logic            found_v, abit, bbit;

`ifdef BMU_BDEP_EN
  logic [XLEN-1:0] atmp;
  assign legal = op <= OP_BDEP;
`else
  assign legal = op <= OP_BEXT;
`endif

  assign ready     = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign valid_out = state_q == DONE;
  assign error     = (state_q == DONE) & err_q;
  assign result_ff = res_q;

  // One chunk per RUN cycle: CLZ walks chunks and bits MSB-first, everything else LSB-first.
  always_comb begin
    cidx    = (op_q == OP_CLZ) ? CW'(K - 1) - cnt_q : cnt_q;
    base    = int'(cidx) * CHUNK;
    ca      = CHUNK'(a_q >> base);
    cb      = CHUNK'(b_q >> base);
    acc_v   = acc_q;
    ptr_v   = ptr_q;
    found_v = found_q;
`ifdef BMU_BDEP_EN
    atmp    = '0;
`endif
    for (int j = 0; j < CHUNK; j++) begin
      abit = (op_q == OP_CLZ) ? ca[CHUNK-1-j] : ca[j];
      bbit = cb[j];
      if (op_q == OP_CLZ || op_q == OP_CTZ) begin
        if (!found_v) begin
          if (abit) found_v = 1'b1;
          else acc_v = acc_v + XLEN'(1);
        end
      end else if (op_q == OP_CPOP) begin
        acc_v = acc_v + XLEN'(abit);
      end else if (op_q == OP_BEXT && bbit) begin
        acc_v = acc_v | (XLEN'(abit) << ptr_v);
        ptr_v = ptr_v + PW'(1);
      end
`ifdef BMU_BDEP_EN
      else if (op_q == OP_BDEP && bbit) begin
        atmp  = a_q >> ptr_v;
        acc_v = acc_v | (XLEN'(atmp[0]) << (base + j));
        ptr_v = ptr_v + PW'(1);
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    err_d   = err_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (valid_in) begin
          op_d    = op;
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          ptr_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
          err_d   = !legal;
          res_d   = legal ? res_q : '0;
          state_d = legal ? RUN : DONE;
        end
        RUN: if (cnt_q == CW'(K)) begin
          res_d   = acc_q;
          state_d = DONE;
        end else begin
          acc_d   = acc_v;
          ptr_d   = ptr_v;
          found_d = found_v;
          cnt_d   = cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end
endmodule
